// File: rtl/time_param_bank.sv
// rtl/time_param_bank.sv - programmable timing-interval bank with shadow commit and countdown timer
//
// Holds NUM_PARAMS interval values. Writes go to shadow registers and only
// reach the active bank when commit is pulsed. A countdown timer loads an
// active interval and pulses expired when the interval has elapsed.
//
// Ports:
//   clk                 system clock
//   reset               asynchronous active-high reset
//   selector            read index and timer-load index
//   t_value_output      active value of entry [selector], 0 when out of range
//   reprogram           single-cycle write strobe
//   selector_reprogram  write index
//   t_value_input       write data (0 is rejected)
//   commit              move all pending shadow values into the active bank
//   pending             at least one shadow write is not yet committed
//   prog_err            one-cycle pulse for a rejected write
//   tick_en             timebase strobe, one cycle per tick
//   start               load the timer from active[selector]
//   busy                timer running
//   expired             one-cycle pulse when the countdown completes

module time_param_bank #(
    parameter int NUM_PARAMS = 4,
    parameter int VALUE_W    = 4,
    parameter int SEL_W      = 2,
    parameter logic [NUM_PARAMS*VALUE_W-1:0] DEFAULTS = {4'd0, 4'd2, 4'd3, 4'd6}
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SEL_W-1:0]   selector,
    output logic [VALUE_W-1:0] t_value_output,
    input  logic               reprogram,
    input  logic [SEL_W-1:0]   selector_reprogram,
    input  logic [VALUE_W-1:0] t_value_input,
    input  logic               commit,
    output logic               pending,
    output logic               prog_err,
    input  logic               tick_en,
    input  logic               start,
    output logic               busy,
    output logic               expired
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    logic [VALUE_W-1:0]    active_q [NUM_PARAMS];
    logic [VALUE_W-1:0]    active_d [NUM_PARAMS];
    logic [VALUE_W-1:0]    shadow_q [NUM_PARAMS];
    logic [VALUE_W-1:0]    shadow_d [NUM_PARAMS];
    logic [NUM_PARAMS-1:0] pend_q;
    logic [NUM_PARAMS-1:0] pend_d;
    logic                  pending_q;
    logic                  pending_d;
    logic                  prog_err_q;
    logic                  prog_err_d;

    state_t                state_q;
    state_t                state_d;
    logic [VALUE_W-1:0]    count_q;
    logic [VALUE_W-1:0]    count_d;
    logic                  expired_q;
    logic                  expired_d;

    logic [VALUE_W-1:0]    rd_value;
    logic                  wr_in_range;
    logic                  wr_ok;

    // Selecting by equality keeps out-of-range selectors from indexing past
    // the array when 2^SEL_W > NUM_PARAMS; they simply read as 0.
    always_comb begin
        rd_value    = '0;
        wr_in_range = 1'b0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (selector == SEL_W'(i)) begin
                rd_value = active_q[i];
            end
            if (selector_reprogram == SEL_W'(i)) begin
                wr_in_range = 1'b1;
            end
        end
    end

    assign wr_ok = reprogram && wr_in_range && (t_value_input != '0);

    // Commit is evaluated against the pre-edge shadow, then the write is
    // applied on top, so a same-cycle write to a committed entry stays pending.
    always_comb begin
        active_d   = active_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        prog_err_d = reprogram && !wr_ok;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            if (commit && pend_q[i]) begin
                active_d[i] = shadow_q[i];
                pend_d[i]   = 1'b0;
            end
            if (wr_ok && (selector_reprogram == SEL_W'(i))) begin
                shadow_d[i] = t_value_input;
                pend_d[i]   = 1'b1;
            end
        end
        pending_d = |pend_d;
    end

    // Timer next state. start wins over tick_en; a zero load never enters RUN,
    // so count is never decremented from 0.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        expired_d = 1'b0;
        if (start) begin
            count_d = rd_value;
            if (rd_value == '0) begin
                state_d   = ST_IDLE;
                expired_d = 1'b1;
            end else begin
                state_d = ST_RUN;
            end
        end else if ((state_q == ST_RUN) && tick_en) begin
            if (count_q > VALUE_W'(1)) begin
                count_d = count_q - VALUE_W'(1);
            end else begin
                count_d   = '0;
                state_d   = ST_IDLE;
                expired_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                active_q[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
                shadow_q[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
            end
            pend_q     <= '0;
            pending_q  <= 1'b0;
            prog_err_q <= 1'b0;
            state_q    <= ST_IDLE;
            count_q    <= '0;
            expired_q  <= 1'b0;
        end else begin
            active_q   <= active_d;
            shadow_q   <= shadow_d;
            pend_q     <= pend_d;
            pending_q  <= pending_d;
            prog_err_q <= prog_err_d;
            state_q    <= state_d;
            count_q    <= count_d;
            expired_q  <= expired_d;
        end
    end

    assign t_value_output = rd_value;
    assign pending        = pending_q;
    assign prog_err       = prog_err_q;
    assign busy           = (state_q == ST_RUN);
    assign expired        = expired_q;

endmodule

// File: tb/tb_time_param_bank.sv
// tb/tb_time_param_bank.sv - self-checking bench for time_param_bank

module tb_time_param_bank;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] selector = '0;
    logic       reprogram = 1'b0;
    logic [1:0] selector_reprogram = '0;
    logic [3:0] t_value_input = '0;
    logic       commit = 1'b0;
    logic       tick_en = 1'b0;
    logic       start = 1'b0;

    logic [3:0] t_value_output;
    logic       pending, prog_err, busy, expired;
    logic [3:0] tv3;
    logic       pend3, pe3, busy3, exp3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    time_param_bank dut (
        .clk(clk), .reset(reset), .selector(selector), .t_value_output(t_value_output),
        .reprogram(reprogram), .selector_reprogram(selector_reprogram),
        .t_value_input(t_value_input), .commit(commit), .pending(pending),
        .prog_err(prog_err), .tick_en(tick_en), .start(start), .busy(busy),
        .expired(expired)
    );

    time_param_bank #(.NUM_PARAMS(3), .VALUE_W(4), .SEL_W(2), .DEFAULTS(12'h236)) dut3 (
        .clk(clk), .reset(reset), .selector(selector), .t_value_output(tv3),
        .reprogram(reprogram), .selector_reprogram(selector_reprogram),
        .t_value_input(t_value_input), .commit(commit), .pending(pend3),
        .prog_err(pe3), .tick_en(tick_en), .start(start), .busy(busy3),
        .expired(exp3)
    );

    // Reference model: interval table, shadow table, pending flags and a
    // remaining-tick counter, updated once per clock edge.
    localparam int NP = 4;
    int m_act [NP];
    int m_sh  [NP];
    bit m_pend [NP];
    int m_left;
    bit m_busy, m_exp, m_perr, m_pending;

    function automatic int rd(int sel);
        return (sel < NP) ? m_act[sel] : 0;
    endfunction

    task automatic model_reset();
        m_act = '{6, 3, 2, 0};
        m_sh  = '{6, 3, 2, 0};
        for (int i = 0; i < NP; i++) m_pend[i] = 1'b0;
        m_left = 0; m_busy = 0; m_exp = 0; m_perr = 0; m_pending = 0;
    endtask

    task automatic model_edge();
        int r;
        int srp;
        r   = rd(int'(selector));
        srp = int'(selector_reprogram);
        m_perr = reprogram && (srp >= NP || t_value_input == 0);
        if (commit) begin
            for (int i = 0; i < NP; i++) begin
                if (m_pend[i]) begin
                    m_act[i]  = m_sh[i];
                    m_pend[i] = 1'b0;
                end
            end
        end
        if (reprogram && !m_perr) begin
            m_sh[srp]   = int'(t_value_input);
            m_pend[srp] = 1'b1;
        end
        m_pending = 1'b0;
        for (int i = 0; i < NP; i++) m_pending |= m_pend[i];
        m_exp = 1'b0;
        if (start) begin
            m_busy = (r != 0);
            m_left = r;
            m_exp  = (r == 0);
        end else if (m_busy && tick_en) begin
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_exp  = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".tv"},      32'(t_value_output), 32'(rd(int'(selector))));
        chk({tag, ".pending"}, 32'(pending),  32'(m_pending));
        chk({tag, ".prog_err"},32'(prog_err), 32'(m_perr));
        chk({tag, ".busy"},    32'(busy),     32'(m_busy));
        chk({tag, ".expired"}, 32'(expired),  32'(m_exp));
    endtask

    // Inputs are stable across the posedge; outputs are sampled at the negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        reprogram = 0; commit = 0; start = 0; tick_en = 0;
        selector_reprogram = '0; t_value_input = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #2;
        reset = 1'b0;
    endtask

    typedef struct {
        int rp, srp, val, cm, sel, st, tk;
        int tv, pd, pe, bz, ex;
    } vec_t;

    vec_t vt [17];

    initial begin
        int n;
        vt[0]  = '{0,0,0, 0,0,0,0,  6,0,0,0,0};
        vt[1]  = '{0,0,0, 0,1,0,0,  3,0,0,0,0};
        vt[2]  = '{0,0,0, 0,2,0,0,  2,0,0,0,0};
        vt[3]  = '{0,0,0, 0,3,0,0,  0,0,0,0,0};
        vt[4]  = '{1,0,10,0,0,0,0,  6,1,0,0,0};
        vt[5]  = '{0,0,0, 1,0,0,0, 10,0,0,0,0};
        vt[6]  = '{1,1,0, 0,1,0,0,  3,0,1,0,0};
        vt[7]  = '{0,0,0, 0,1,0,0,  3,0,0,0,0};
        vt[8]  = '{1,1,5, 0,1,0,0,  3,1,0,0,0};
        vt[9]  = '{1,1,7, 1,1,0,0,  5,1,0,0,0};
        vt[10] = '{0,0,0, 1,1,0,0,  7,0,0,0,0};
        vt[11] = '{0,0,0, 0,2,1,1,  2,0,0,1,0};
        vt[12] = '{0,0,0, 0,2,0,1,  2,0,0,1,0};
        vt[13] = '{0,0,0, 0,2,0,1,  2,0,0,0,1};
        vt[14] = '{0,0,0, 0,2,0,1,  2,0,0,0,0};
        vt[15] = '{0,0,0, 0,3,1,1,  0,0,0,0,1};
        vt[16] = '{0,0,0, 0,3,0,1,  0,0,0,0,0};

        idle_inputs();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state, asynchronous
        do_reset();
        chk("rst.pending", 32'(pending), 32'd0);
        chk("rst.busy",    32'(busy),    32'd0);
        chk("rst.expired", 32'(expired), 32'd0);

        // Directed table
        for (int i = 0; i < 17; i++) begin
            reprogram          = vt[i].rp[0];
            selector_reprogram = 2'(vt[i].srp);
            t_value_input      = 4'(vt[i].val);
            commit             = vt[i].cm[0];
            selector           = 2'(vt[i].sel);
            start              = vt[i].st[0];
            tick_en            = vt[i].tk[0];
            step();
            chk($sformatf("vec%0d.tv", i),       32'(t_value_output), 32'(vt[i].tv));
            chk($sformatf("vec%0d.pending", i),  32'(pending),  32'(vt[i].pd));
            chk($sformatf("vec%0d.prog_err", i), 32'(prog_err), 32'(vt[i].pe));
            chk($sformatf("vec%0d.busy", i),     32'(busy),     32'(vt[i].bz));
            chk($sformatf("vec%0d.expired", i),  32'(expired),  32'(vt[i].ex));
        end
        idle_inputs();

        // Sparse ticks: value 2 with a tick every 4th cycle expires on cycle 8
        selector = 2; start = 1; step(); start = 0;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            tick_en = (c % 4 == 0);
            step();
            check_model("sparse");
            if (expired) begin n = c; break; end
        end
        chk("sparse.expiry_cycle", 32'(n), 32'd8);
        idle_inputs();

        // Out-of-range write on a 3-entry bank, zero-value write on both
        do_reset();
        reprogram = 1; selector_reprogram = 3; t_value_input = 5; selector = 3;
        step();
        chk("np3.prog_err",  32'(pe3),   32'd1);
        chk("np3.pending",   32'(pend3), 32'd0);
        chk("np3.tv_sel3",   32'(tv3),   32'd0);
        check_model("np4_write3");
        reprogram = 1; selector_reprogram = 2; t_value_input = 0; selector = 2;
        step();
        chk("np3.zero_err",  32'(pe3), 32'd1);
        chk("np3.tv_sel2",   32'(tv3), 32'd2);
        check_model("zero_write");
        reprogram = 0; step();
        chk("np3.err_clear", 32'(pe3), 32'd0);
        check_model("err_clear");
        commit = 1; step(); commit = 0;
        check_model("commit3");

        // Reset mid-count, then a restart with a different entry
        do_reset();
        selector = 0; tick_en = 1; start = 1; step(); start = 0;
        check_model("base_start");
        for (int c = 0; c < 3; c++) begin step(); check_model("base_tick"); end
        #2 reset = 1'b1;
        #1;
        chk("midrst.busy",    32'(busy),           32'd0);
        chk("midrst.expired", 32'(expired),        32'd0);
        chk("midrst.tv",      32'(t_value_output), 32'd6);
        model_reset();
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin step(); check_model("post_rst"); end
        start = 1; step(); start = 0;
        step(); step();
        check_model("pre_restart");
        selector = 1; start = 1; step(); start = 0;
        n = 0;
        for (int c = 1; c <= 20; c++) begin
            step();
            check_model("restart");
            if (expired) begin n = c; break; end
        end
        chk("restart.expiry_cycle", 32'(n), 32'd3);
        idle_inputs();

        // Randomised run against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            reprogram          = ($urandom_range(3) == 0);
            selector_reprogram = 2'($urandom_range(3));
            t_value_input      = ($urandom_range(7) == 0) ? 4'd0 : 4'($urandom_range(15));
            commit             = ($urandom_range(5) == 0);
            selector           = 2'($urandom_range(3));
            start              = ($urandom_range(9) == 0);
            tick_en            = ($urandom_range(1) == 0);
            step();
            check_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
